mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory (M) pipeline stage. Sits directly downstream of the Execute stage and upstream of Writeback.
- Registers the Execute→Memory payload and aligns and sign/zero-extends the raw load word already returned to Execute.
- Drives the M→D forwarding bus and the M→W payload.
- Tracks exception state so younger instructions are squashed until the global flush (ex_en).

Parameters:
- RST_PC, 32'h1c000000, value presented on mw_pc while the stage is empty after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  asynchronous active-low reset
- EM_valid  in  1  Execute has an instruction ready to hand over
- M_allowin  out  1  stage can accept from Execute this cycle
- W_allowin  in  1  Writeback can accept this cycle
- MW_valid  out  1  stage presents a valid instruction to Writeback
- em_pc  in  32  instruction PC
- em_rf_wdata  in  32  ALU/CSR result, or raw 32-bit load word
- em_gr_we  in  1  regfile write enable
- em_dest  in  5  destination register
- em_ld_mask  in  4  0000 not load, 0001 byte, 0011 half, 1111 word
- em_ld_unsigned  in  1  zero-extend (ld.bu/ld.hu)
- em_vaddr  in  32  data address (byte lane select; BADV on exception)
- em_ex  in  1  exception raised at or before Execute
- em_ecode  in  8  exception code
- em_esubcode  in  1  exception subcode
- em_csr_we  in  1  CSR write
- em_csr_addr  in  14  CSR number
- em_csr_wdata  in  32  pre-merged CSR write data
- ex_en  in  1  global exception/ertn flush pulse from Writeback
- ex_M  out  1  valid instruction in M carries an exception
- mw_pc, mw_rf_wdata  out  32 each  to Writeback
- mw_gr_we  out  1  write enable to Writeback
- mw_dest  out  5  destination to Writeback
- mw_vaddr  out  32  address to Writeback
- mw_ex  out  1  exception flag to Writeback
- mw_ecode  out  8  exception code to Writeback
- mw_esubcode  out  1  exception subcode to Writeback
- mw_csr_we  out  1  CSR write to Writeback
- mw_csr_addr  out  14  CSR number to Writeback
- mw_csr_wdata  out  32  CSR write data to Writeback
- fwd_dest  out  5  forward destination; 0 when no valid GR write
- fwd_wdata  out  32  final (extended) write data
- fwd_csr_we  out  1  valid CSR write in M
- fwd_csr_addr  out  14  CSR number for forwarding

Behaviour:
- Reset (asynchronous, rstn=0):
  - M_valid=0, ex_flag=0, payload register cleared, stored PC = RST_PC.
  - All outputs read 0, except mw_pc=RST_PC.
  - M_allowin=1 during reset.
  - Deassertion takes effect on the next clk edge only.
- Handshake:
  - M_ready_go=1; the stage never stalls internally.
  - M_allowin = !M_valid || W_allowin.
  - MW_valid = M_valid.
  - Payload registers load when EM_valid && M_allowin. Payload is held unchanged otherwise, including while W_allowin=0.
- Valid update priority per edge:
  1. ex_en=1 → M_valid←0, payload cleared.
  2. Otherwise, if M_allowin → M_valid ← EM_valid && !ex_flag && !ex_M.
- Latency: one cycle Execute→Writeback when there is no backpressure.
- ex_flag:
  - Set on any edge where ex_M=1.
  - Cleared on ex_en, which has priority.
  - While set, instructions accepted from Execute enter with valid=0. They drain but produce no GR/CSR side effects.
- ex_M and exception fields:
  - ex_M = M_valid && stored ex.
  - mw_ex = ex_M. mw_ecode/mw_esubcode are the stored values, gated to 0 when !M_valid.
- Load extraction, lane select = vaddr[1:0]:
  - byte: lane k gives bits [8k+7:8k].
  - half: vaddr[1]=0 gives [15:0]; vaddr[1]=1 gives [31:16].
  - word: unchanged.
  - Sign-extend, or zero-extend when ld_unsigned.
  - Non-load: rf_wdata passes through unchanged.
  - Misaligned loads cannot reach this stage without ex set. When ex is set, data is don't-care and mw_gr_we=0.
- Write-enable and forwarding gating:
  - mw_gr_we = M_valid && gr_we && !ex. mw_csr_we = M_valid && csr_we && !ex.
  - fwd_dest = mw_gr_we ? dest : 0. fwd_wdata = final data. fwd_csr_we = mw_csr_we.
  - Forwarding outputs are valid in the same cycle the instruction sits in M, including cycles held by backpressure.
- Simultaneous events:
  - ex_en together with EM_valid: the incoming instruction is dropped.
  - ex_M held while W_allowin=0: ex_flag is already set and the stored instruction remains.

Test Plan:
- ld.b, em_rf_wdata=32'h12F45678, vaddr[1:0]=2'b10, signed → mw_rf_wdata=32'hFFFFFFF4 one cycle later, fwd_dest=em_dest.
- ld.hu, same word, vaddr[1]=1 → 32'h000012F4; ld.h, vaddr[1]=0 → 32'h00005678; ld.w → 32'h12F45678.
- Hold W_allowin=0 for 3 cycles with an add (dest=5) in M → M_allowin=0, outputs stable, fwd_dest=5 every cycle; release → next EM payload accepted on that edge.
- Instruction with em_ex=1, ecode=8'h09 → ex_M=1, mw_gr_we=0. Next two EM_valid instructions accepted with MW_valid=0. ex_en pulse → ex_flag cleared, following instruction flows normally.
- Assert rstn=0 asynchronously mid-transfer with M_valid=1 → MW_valid and ex_M drop before the next clk edge, mw_pc=RST_PC.
- ex_en and EM_valid in the same cycle with a csr_we instruction incoming → MW_valid=0 and fwd_csr_we=0 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory pipeline stage. Registers the Execute payload, aligns and
//            extends load data, drives M->W payload and M->D forwarding, and
//            squashes younger instructions after an exception until flush.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter logic [31:0] RST_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        EM_valid,
  output logic        M_allowin,
  input  logic        W_allowin,
  output logic        MW_valid,
  input  logic [31:0] em_pc,
  input  logic [31:0] em_rf_wdata,
  input  logic        em_gr_we,
  input  logic [4:0]  em_dest,
  input  logic [3:0]  em_ld_mask,
  input  logic        em_ld_unsigned,
  input  logic [31:0] em_vaddr,
  input  logic        em_ex,
  input  logic [7:0]  em_ecode,
  input  logic        em_esubcode,
  input  logic        em_csr_we,
  input  logic [13:0] em_csr_addr,
  input  logic [31:0] em_csr_wdata,
  input  logic        ex_en,
  output logic        ex_M,
  output logic [31:0] mw_pc,
  output logic [31:0] mw_rf_wdata,
  output logic        mw_gr_we,
  output logic [4:0]  mw_dest,
  output logic [31:0] mw_vaddr,
  output logic        mw_ex,
  output logic [7:0]  mw_ecode,
  output logic        mw_esubcode,
  output logic        mw_csr_we,
  output logic [13:0] mw_csr_addr,
  output logic [31:0] mw_csr_wdata,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_wdata,
  output logic        fwd_csr_we,
  output logic [13:0] fwd_csr_addr
);

  localparam logic [3:0] c_MASK_BYTE = 4'b0001;
  localparam logic [3:0] c_MASK_HALF = 4'b0011;

  logic        r_valid;
  logic        r_ex_flag;
  logic [31:0] r_pc;
  logic [31:0] r_wdata;
  logic        r_gr_we;
  logic [4:0]  r_dest;
  logic [3:0]  r_ld_mask;
  logic        r_ld_unsigned;
  logic [31:0] r_vaddr;
  logic        r_ex;
  logic [7:0]  r_ecode;
  logic        r_esubcode;
  logic        r_csr_we;
  logic [13:0] r_csr_addr;
  logic [31:0] r_csr_wdata;

  logic        w_ex_m;
  logic        w_accept;
  logic        w_gr_we;
  logic        w_csr_we;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_final;

  // The stage never stalls itself, so it can take a new instruction whenever
  // it is empty or its current occupant is leaving.
  assign w_ex_m    = r_valid & r_ex;
  assign M_allowin = !r_valid || W_allowin;
  assign w_accept  = EM_valid && M_allowin;

  // Valid bit and sticky exception flag; flush wins over everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid   <= 1'b0;
      r_ex_flag <= 1'b0;
    end else if (ex_en) begin
      r_valid   <= 1'b0;
      r_ex_flag <= 1'b0;
    end else begin
      if (w_ex_m)
        r_ex_flag <= 1'b1;
      // Anything younger than an exception enters as a bubble.
      if (M_allowin)
        r_valid <= EM_valid && !r_ex_flag && !w_ex_m;
    end
  end

  // Payload register: cleared on flush, loaded on handshake, held otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || ex_en) begin
      r_pc          <= RST_PC;
      r_wdata       <= 32'd0;
      r_gr_we       <= 1'b0;
      r_dest        <= 5'd0;
      r_ld_mask     <= 4'd0;
      r_ld_unsigned <= 1'b0;
      r_vaddr       <= 32'd0;
      r_ex          <= 1'b0;
      r_ecode       <= 8'd0;
      r_esubcode    <= 1'b0;
      r_csr_we      <= 1'b0;
      r_csr_addr    <= 14'd0;
      r_csr_wdata   <= 32'd0;
    end else if (w_accept) begin
      r_pc          <= em_pc;
      r_wdata       <= em_rf_wdata;
      r_gr_we       <= em_gr_we;
      r_dest        <= em_dest;
      r_ld_mask     <= em_ld_mask;
      r_ld_unsigned <= em_ld_unsigned;
      r_vaddr       <= em_vaddr;
      r_ex          <= em_ex;
      r_ecode       <= em_ecode;
      r_esubcode    <= em_esubcode;
      r_csr_we      <= em_csr_we;
      r_csr_addr    <= em_csr_addr;
      r_csr_wdata   <= em_csr_wdata;
    end
  end

  // Lane selection and extension of the raw load word.
  always_comb begin
    w_byte  = r_wdata[7:0];
    w_half  = r_vaddr[1] ? r_wdata[31:16] : r_wdata[15:0];
    w_final = r_wdata;
    case (r_vaddr[1:0])
      2'd0:    w_byte = r_wdata[7:0];
      2'd1:    w_byte = r_wdata[15:8];
      2'd2:    w_byte = r_wdata[23:16];
      default: w_byte = r_wdata[31:24];
    endcase
    case (r_ld_mask)
      c_MASK_BYTE: w_final = r_ld_unsigned ? {24'd0, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
      c_MASK_HALF: w_final = r_ld_unsigned ? {16'd0, w_half}
                                           : {{16{w_half[15]}}, w_half};
      default:     w_final = r_wdata;
    endcase
  end

  // Side effects only for a valid, exception-free instruction.
  assign w_gr_we  = r_valid & r_gr_we & !r_ex;
  assign w_csr_we = r_valid & r_csr_we & !r_ex;

  assign MW_valid     = r_valid;
  assign ex_M         = w_ex_m;
  assign mw_pc        = r_pc;
  assign mw_rf_wdata  = w_final;
  assign mw_gr_we     = w_gr_we;
  assign mw_dest      = r_dest;
  assign mw_vaddr     = r_vaddr;
  assign mw_ex        = w_ex_m;
  assign mw_ecode     = r_valid ? r_ecode : 8'd0;
  assign mw_esubcode  = r_valid & r_esubcode;
  assign mw_csr_we    = w_csr_we;
  assign mw_csr_addr  = r_csr_addr;
  assign mw_csr_wdata = r_csr_wdata;
  assign fwd_dest     = w_gr_we ? r_dest : 5'd0;
  assign fwd_wdata    = w_final;
  assign fwd_csr_we   = w_csr_we;
  assign fwd_csr_addr = r_csr_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage with a transaction-level
//            reference model and directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        EM_valid = 1'b0, W_allowin = 1'b1, ex_en = 1'b0;
  logic [31:0] em_pc = '0, em_rf_wdata = '0, em_vaddr = '0, em_csr_wdata = '0;
  logic        em_gr_we = 1'b0, em_ld_unsigned = 1'b0, em_ex = 1'b0;
  logic        em_esubcode = 1'b0, em_csr_we = 1'b0;
  logic [4:0]  em_dest = '0;
  logic [3:0]  em_ld_mask = '0;
  logic [7:0]  em_ecode = '0;
  logic [13:0] em_csr_addr = '0;

  logic        M_allowin, MW_valid, ex_M, mw_gr_we, mw_ex, mw_esubcode, mw_csr_we, fwd_csr_we;
  logic [31:0] mw_pc, mw_rf_wdata, mw_vaddr, mw_csr_wdata, fwd_wdata;
  logic [4:0]  mw_dest, fwd_dest;
  logic [7:0]  mw_ecode;
  logic [13:0] mw_csr_addr, fwd_csr_addr;

  mem_stage #(.RST_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .EM_valid(EM_valid), .M_allowin(M_allowin),
    .W_allowin(W_allowin), .MW_valid(MW_valid), .em_pc(em_pc),
    .em_rf_wdata(em_rf_wdata), .em_gr_we(em_gr_we), .em_dest(em_dest),
    .em_ld_mask(em_ld_mask), .em_ld_unsigned(em_ld_unsigned), .em_vaddr(em_vaddr),
    .em_ex(em_ex), .em_ecode(em_ecode), .em_esubcode(em_esubcode),
    .em_csr_we(em_csr_we), .em_csr_addr(em_csr_addr), .em_csr_wdata(em_csr_wdata),
    .ex_en(ex_en), .ex_M(ex_M), .mw_pc(mw_pc), .mw_rf_wdata(mw_rf_wdata),
    .mw_gr_we(mw_gr_we), .mw_dest(mw_dest), .mw_vaddr(mw_vaddr), .mw_ex(mw_ex),
    .mw_ecode(mw_ecode), .mw_esubcode(mw_esubcode), .mw_csr_we(mw_csr_we),
    .mw_csr_addr(mw_csr_addr), .mw_csr_wdata(mw_csr_wdata), .fwd_dest(fwd_dest),
    .fwd_wdata(fwd_wdata), .fwd_csr_we(fwd_csr_we), .fwd_csr_addr(fwd_csr_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc, wdata, vaddr, csr_wdata;
    logic        gr_we, uns, ex, esub, csr_we;
    logic [4:0]  dest;
    logic [3:0]  mask;
    logic [7:0]  ecode;
    logic [13:0] csr_addr;
  } insn_t;

  insn_t m_slot;          // what is parked in M
  bit    m_live  = 0;     // the parked instruction is real
  bit    m_squash = 0;    // an exception has been seen and not yet flushed
  bit    chk_en  = 0;

  function automatic insn_t empty_insn();
    insn_t t = '0;
    t.pc = RST_PC;
    return t;
  endfunction

  // Load result computed arithmetically from the lane offset.
  function automatic logic [31:0] load_value(insn_t t);
    longint v;
    if (t.mask == 4'b0001) begin
      v = (t.wdata >> (8 * t.vaddr[1:0])) & 32'hFF;
      if (!t.uns && v >= 128) v = v - 256;
    end else if (t.mask == 4'b0011) begin
      v = (t.wdata >> (16 * t.vaddr[1])) & 32'hFFFF;
      if (!t.uns && v >= 32768) v = v - 65536;
    end else begin
      v = t.wdata;
    end
    return v[31:0];
  endfunction

  function automatic bit m_exc();
    return m_live && m_slot.ex;
  endfunction
  function automatic bit m_writes_gr();
    return m_live && m_slot.gr_we && !m_slot.ex;
  endfunction
  function automatic bit m_writes_csr();
    return m_live && m_slot.csr_we && !m_slot.ex;
  endfunction

  initial m_slot = empty_insn();

  always @(posedge clk or negedge rstn) begin : model
    insn_t incoming;
    bit room, was_exc;
    if (!rstn) begin
      m_live = 0; m_squash = 0; m_slot = empty_insn();
    end else begin
      room    = !m_live || W_allowin;
      was_exc = m_exc();
      incoming = '{pc: em_pc, wdata: em_rf_wdata, vaddr: em_vaddr, csr_wdata: em_csr_wdata,
                   gr_we: em_gr_we, uns: em_ld_unsigned, ex: em_ex, esub: em_esubcode,
                   csr_we: em_csr_we, dest: em_dest, mask: em_ld_mask, ecode: em_ecode,
                   csr_addr: em_csr_addr};
      if (ex_en) begin
        m_live = 0; m_squash = 0; m_slot = empty_insn();
      end else if (room) begin
        m_live = EM_valid && !m_squash && !was_exc;
        if (EM_valid) m_slot = incoming;
        if (was_exc) m_squash = 1;
      end else if (was_exc) begin
        m_squash = 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("M_allowin", M_allowin, !m_live || W_allowin);
      check("MW_valid", MW_valid, m_live);
      check("ex_M", ex_M, m_exc());
      check("mw_ex", mw_ex, m_exc());
      check("mw_pc", mw_pc, m_slot.pc);
      check("mw_rf_wdata", mw_rf_wdata, load_value(m_slot));
      check("fwd_wdata", fwd_wdata, load_value(m_slot));
      check("mw_gr_we", mw_gr_we, m_writes_gr());
      check("fwd_dest", fwd_dest, m_writes_gr() ? m_slot.dest : 5'd0);
      check("mw_dest", mw_dest, m_slot.dest);
      check("mw_vaddr", mw_vaddr, m_slot.vaddr);
      check("mw_ecode", mw_ecode, m_live ? m_slot.ecode : 8'd0);
      check("mw_esubcode", mw_esubcode, m_live && m_slot.esub);
      check("mw_csr_we", mw_csr_we, m_writes_csr());
      check("fwd_csr_we", fwd_csr_we, m_writes_csr());
      check("mw_csr_addr", mw_csr_addr, m_slot.csr_addr);
      check("fwd_csr_addr", fwd_csr_addr, m_slot.csr_addr);
      check("mw_csr_wdata", mw_csr_wdata, m_slot.csr_wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] wd, input logic gw,
                      input logic [4:0] dst, input logic [3:0] msk, input logic uns,
                      input logic [31:0] va, input logic ex, input logic [7:0] ec,
                      input logic cw);
    EM_valid = 1; em_pc = pc; em_rf_wdata = wd; em_gr_we = gw; em_dest = dst;
    em_ld_mask = msk; em_ld_unsigned = uns; em_vaddr = va; em_ex = ex;
    em_ecode = ec; em_esubcode = ex; em_csr_we = cw; em_csr_addr = pc[13:0];
    em_csr_wdata = ~wd;
  endtask

  task automatic idle();
    EM_valid = 0;
  endtask

  initial begin
    // Reset state
    #1;
    @(posedge clk); chk_en = 1; #2;
    check("rst_mw_pc", mw_pc, RST_PC);
    check("rst_MW_valid", MW_valid, 0);
    check("rst_allowin", M_allowin, 1);
    tick();
    rstn = 1;
    tick();

    // Load extraction on 32'h12F45678
    send(32'h1c000100, 32'h12F45678, 1, 5'd3, 4'b0001, 0, 32'h00001002, 0, 8'h0, 0);
    tick();
    check("ldb_data", mw_rf_wdata, 32'hFFFFFFF4);
    check("ldb_fwd_dest", fwd_dest, 5'd3);
    check("ldb_valid", MW_valid, 1);
    send(32'h1c000104, 32'h12F45678, 1, 5'd4, 4'b0011, 1, 32'h00001002, 0, 8'h0, 0);
    tick();
    check("ldhu_data", mw_rf_wdata, 32'h000012F4);
    send(32'h1c000108, 32'h12F45678, 1, 5'd4, 4'b0011, 0, 32'h00001000, 0, 8'h0, 0);
    tick();
    check("ldh_data", mw_rf_wdata, 32'h00005678);
    send(32'h1c00010c, 32'h12F45678, 1, 5'd4, 4'b1111, 0, 32'h00001000, 0, 8'h0, 0);
    tick();
    check("ldw_data", mw_rf_wdata, 32'h12F45678);
    send(32'h1c000110, 32'h8080F0F0, 1, 5'd2, 4'b0001, 0, 32'h00001003, 0, 8'h0, 0);
    tick();
    check("ldb3_data", mw_rf_wdata, 32'hFFFFFF80);
    send(32'h1c000114, 32'h8080F0F0, 1, 5'd2, 4'b0011, 0, 32'h00001002, 0, 8'h0, 1);
    tick();
    check("ldh_hi_neg", mw_rf_wdata, 32'hFFFF8080);

    // Backpressure: add to r5 held for three cycles
    send(32'h1c000200, 32'hAAAA5555, 1, 5'd5, 4'b0000, 0, 32'h0, 0, 8'h0, 0);
    tick();
    W_allowin = 0;
    send(32'h1c000204, 32'h00000066, 1, 5'd6, 4'b0000, 0, 32'h0, 0, 8'h0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_allowin", M_allowin, 0);
      check("bp_fwd_dest", fwd_dest, 5'd5);
      check("bp_data", mw_rf_wdata, 32'hAAAA5555);
      tick();
    end
    W_allowin = 1;
    tick();
    check("bp_release_dest", fwd_dest, 5'd6);
    check("bp_release_pc", mw_pc, 32'h1c000204);

    // Exception, two squashed followers, flush with a colliding CSR write
    send(32'h1c000300, 32'h11111111, 1, 5'd7, 4'b0000, 0, 32'hBAD00001, 1, 8'h09, 0);
    tick();
    check("exc_ex_M", ex_M, 1);
    check("exc_gr_we", mw_gr_we, 0);
    check("exc_ecode", mw_ecode, 8'h09);
    send(32'h1c000304, 32'h22222222, 1, 5'd8, 4'b0000, 0, 32'h0, 0, 8'h0, 0);
    tick();
    check("sq1_valid", MW_valid, 0);
    check("sq1_allowin", M_allowin, 1);
    send(32'h1c000308, 32'h33333333, 1, 5'd9, 4'b0000, 0, 32'h0, 0, 8'h0, 1);
    tick();
    check("sq2_valid", MW_valid, 0);
    check("sq2_csr_we", fwd_csr_we, 0);
    ex_en = 1;
    send(32'h1c00030c, 32'h44444444, 0, 5'd0, 4'b0000, 0, 32'h0, 0, 8'h0, 1);
    tick();
    ex_en = 0;
    check("flush_valid", MW_valid, 0);
    check("flush_csr_we", fwd_csr_we, 0);
    send(32'h1c000310, 32'h55555555, 1, 5'd10, 4'b0000, 0, 32'h0, 0, 8'h0, 0);
    tick();
    check("post_flush_valid", MW_valid, 1);
    check("post_flush_dest", fwd_dest, 5'd10);

    // Flush colliding with a CSR write while no exception is pending
    ex_en = 1;
    send(32'h1c000400, 32'h00000077, 0, 5'd0, 4'b0000, 0, 32'h0, 0, 8'h0, 1);
    tick();
    ex_en = 0;
    idle();
    check("drop_valid", MW_valid, 0);
    check("drop_csr_we", fwd_csr_we, 0);
    send(32'h1c000404, 32'h00000088, 0, 5'd0, 4'b0000, 0, 32'h0, 0, 8'h0, 1);
    tick();
    check("csr_fwd_we", fwd_csr_we, 1);
    check("csr_fwd_addr", fwd_csr_addr, 14'h0404);

    // Exception held under backpressure
    send(32'h1c000500, 32'h0, 1, 5'd11, 4'b0000, 0, 32'h0, 1, 8'h0A, 0);
    tick();
    W_allowin = 0;
    send(32'h1c000504, 32'h0, 1, 5'd12, 4'b0000, 0, 32'h0, 0, 8'h0, 0);
    tick();
    check("exbp_ex_M", ex_M, 1);
    check("exbp_pc", mw_pc, 32'h1c000500);
    W_allowin = 1;
    tick();
    check("exbp_sq_valid", MW_valid, 0);
    ex_en = 1; idle();
    tick();
    ex_en = 0;

    // Asynchronous reset with an excepting instruction in M
    send(32'h1c000600, 32'h0, 1, 5'd13, 4'b0000, 0, 32'h0, 1, 8'h09, 0);
    tick();
    idle();
    check("pre_rst_ex_M", ex_M, 1);
    #1 rstn = 0;
    #1;
    check("async_MW_valid", MW_valid, 0);
    check("async_ex_M", ex_M, 0);
    check("async_mw_pc", mw_pc, RST_PC);
    check("async_allowin", M_allowin, 1);
    tick();
    rstn = 1;
    send(32'h1c000700, 32'h000000AB, 1, 5'd14, 4'b0001, 1, 32'h0, 0, 8'h0, 0);
    tick();
    idle();
    check("after_rst_data", mw_rf_wdata, 32'h000000AB);
    check("after_rst_dest", fwd_dest, 5'd14);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
